// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants and result type for the full_adder slice.
// Optional feature macro used by the slice: FULL_ADDER_SELF_CHECK_EN.
package full_adder_pkg;

    // Widest operand the adder is meant to be built with.
    localparam int unsigned FA_MAX_WIDTH = 64;

    // Width of the packaged result type; users of other widths override locally.
    localparam int unsigned FA_WIDTH = 1;

    // Packed adder result, carry-out in the MSB so {cout, sum} reads as a number.
    typedef struct packed {
        logic                cout;
        logic [FA_WIDTH-1:0] sum;
    } fa_result_t;

    // Pack a carry and a sum into the shared result type.
    function automatic fa_result_t fa_pack(input logic cout, input logic [FA_WIDTH-1:0] sum);
        fa_result_t r;
        r.cout = cout;
        r.sum  = sum;
        return r;
    endfunction

    // Plain arithmetic reference for one packaged-width addition.
    function automatic fa_result_t fa_ref_add(input logic [FA_WIDTH-1:0] a,
                                              input logic [FA_WIDTH-1:0] b,
                                              input logic                cin);
        logic [FA_WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b} + {{FA_WIDTH{1'b0}}, cin};
        return fa_pack(full[FA_WIDTH], full[FA_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit full adder leaf, sum and majority carry.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    // Sum is the parity of the three inputs; carry is their majority.
    always_comb begin
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple adder with a zero-latency result and a
// registered, valid-qualified copy of that result.
// Optional feature macro: FULL_ADDER_SELF_CHECK_EN adds a sticky err output
// driven by a reference adder compared on every rising clock edge.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid
`ifdef FULL_ADDER_SELF_CHECK_EN
    ,
    output logic             err
`endif
);

    // Reject out-of-range widths at elaboration.
    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH must be within 1..%0d", FA_MAX_WIDTH);
    end

    // Ripple chain: each stage keeps its own carry nets so the chain is not
    // one self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic ci;
        logic co;
        logic s;

        if (i == 0) begin : g_first
            assign ci = Cin;
        end else begin : g_rest
            assign ci = g_bit[i-1].co;
        end

        full_adder_cell u_cell (
            .a  (X[i]),
            .b  (Y[i]),
            .c  (ci),
            .s  (s),
            .co (co)
        );

        assign Sum[i] = s;
    end

    assign Cout = g_bit[WIDTH-1].co;

    // Output register: capture on in_valid, otherwise hold data and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= Sum;
                cout_q <= Cout;
            end
        end
    end

`ifdef FULL_ADDER_SELF_CHECK_EN
    logic [WIDTH:0] ref_result;
    logic [WIDTH:0] dut_result;
    logic           mismatch;

    // Independent arithmetic reference for the ripple chain.
    always_comb begin
        ref_result = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};
        dut_result = {Cout, Sum};
        mismatch   = (ref_result != dut_result);
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Report the offending operands whenever the chain disagrees with the reference.
    always @(posedge clk) begin
        if (rst_n && mismatch) begin
            $display("full_adder self-check: X=%h Y=%h Cin=%b -> Cout=%b Sum=%h (ref %h)",
                     X, Y, Cin, Cout, Sum, ref_result);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed checks of full_adder at WIDTH=1 and WIDTH=8
// against an arithmetic reference model.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       v = 1'b0;

    logic       x1 = 1'b0, y1 = 1'b0, cin1 = 1'b0;
    logic       sum1, cout1, sq1, cq1, ov1;

    logic [7:0] x8 = '0, y8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] sum8, sq8;
    logic       cout8, cq8, ov8;

`ifdef FULL_ADDER_SELF_CHECK_EN
    logic       err1, err8;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state of the registered path.
    logic [1:0] e1_q = '0;
    logic [8:0] e8_q = '0;
    logic       eov  = 1'b0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (x1),
        .Y         (y1),
        .Cin       (cin1),
        .in_valid  (v),
        .Sum       (sum1),
        .Cout      (cout1),
        .sum_q     (sq1),
        .cout_q    (cq1),
        .out_valid (ov1)
`ifdef FULL_ADDER_SELF_CHECK_EN
        ,
        .err       (err1)
`endif
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (x8),
        .Y         (y8),
        .Cin       (cin8),
        .in_valid  (v),
        .Sum       (sum8),
        .Cout      (cout8),
        .sum_q     (sq8),
        .cout_q    (cq8),
        .out_valid (ov8)
`ifdef FULL_ADDER_SELF_CHECK_EN
        ,
        .err       (err8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
        return 2'(int'(a) + int'(b) + int'(c));
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        return 9'(int'(a) + int'(b) + int'(c));
    endfunction

    task automatic check_comb();
        check("comb1", 64'({cout1, sum1}), 64'(ref1(x1, y1, cin1)));
        check("comb8", 64'({cout8, sum8}), 64'(ref8(x8, y8, cin8)));
    endtask

    task automatic check_regs();
        check("reg1", 64'({cq1, sq1}), 64'(e1_q));
        check("reg8", 64'({cq8, sq8}), 64'(e8_q));
        check("ov1", 64'(ov1), 64'(eov));
        check("ov8", 64'(ov8), 64'(eov));
`ifdef FULL_ADDER_SELF_CHECK_EN
        check("err1", 64'(err1), 64'(0));
        check("err8", 64'(err8), 64'(0));
`endif
    endtask

    // Drive one cycle of operands, let the edge capture them, then compare.
    task automatic step(input logic a, input logic b, input logic c,
                        input logic [7:0] a8, input logic [7:0] b8, input logic c8,
                        input logic vin);
        x1 = a; y1 = b; cin1 = c;
        x8 = a8; y8 = b8; cin8 = c8;
        v = vin;
        @(posedge clk);
        if (vin) begin
            e1_q = ref1(a, b, c);
            e8_q = ref8(a8, b8, c8);
        end
        eov = vin;
        #1;
        check_comb();
        check_regs();
    endtask

    initial begin
        // Reset asserted asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check_regs();
        check_comb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive WIDTH=1 truth table, in_valid low.
        for (int i = 0; i < 8; i++) begin
            {x1, y1, cin1} = 3'(i);
            x8 = 8'(i * 37);
            y8 = 8'(i * 91);
            cin8 = x1;
            #10;
            check_comb();
        end
        check_regs();

        @(posedge clk);
        #1;

        // Directed WIDTH=8 boundaries alongside the 1-bit latency check.
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
        check("lat_sum_q", 64'(sq1), 64'(0));
        check("lat_cout_q", 64'(cq1), 64'(1));
        check("ff_plus_cin", 64'({cq8, sq8}), 64'(9'h100));
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0);

        // Back-to-back captures.
        step(1'b0, 1'b0, 1'b1, 8'h5A, 8'hA5, 1'b0, 1'b1);
        check("b2b0", 64'({cq1, sq1}), 64'(2'b01));
        check("5a_a5", 64'({cq8, sq8}), 64'(9'h0FF));
        step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        check("b2b1", 64'({cq1, sq1}), 64'(2'b11));
        check("all_ones", 64'({cq8, sq8}), 64'(9'h1FF));
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("all_zero", 64'({cq8, sq8}), 64'(0));

        // Async reset between edges while a fresh result is held.
        step(1'b1, 1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
        check("pre_rst_ov", 64'(ov1), 64'(1));
        #3;
        rst_n = 1'b0;
        e1_q = '0;
        e8_q = '0;
        eov  = 1'b0;
        #1;
        check_regs();
        x1 = 1'b1; y1 = 1'b1; cin1 = 1'b1;
        x8 = 8'hC3; y8 = 8'h3C; cin8 = 1'b1;
        #1;
        check_comb();
        v = 1'b0;
        @(negedge clk);
        check_regs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs();

        // Randomized traffic.
        repeat (300) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
